axis_rr_input_arbiter: RTL
==========================

Name: axis_rr_input_arbiter

Overview:
- Merges NUM_PORTS AXI4-Stream ingress ports (MAC RX queues plus DMA) into one stream that feeds the output port lookup stage.
- Each input has its own small fall-through buffer.
- A packet-granular round-robin arbiter forwards whole packets without interleaving.
- TUSER is forwarded unmodified, so the source-port field written by the MACs and DMA arrives intact downstream.

Parameters:
- C_AXIS_DATA_WIDTH, 512, TDATA width for all ports; TKEEP is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, TUSER width for all ports.
- NUM_PORTS, 5, number of slave inputs; legal range 2..8.
- FIFO_DEPTH_BITS, 2, log2 of the per-input buffer depth (default depth 4).

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_reset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_PORTS*C_AXIS_DATA_WIDTH  packed; port i at slice [i*W +: W].
- s_axis_tkeep  in  NUM_PORTS*C_AXIS_DATA_WIDTH/8  packed per port.
- s_axis_tuser  in  NUM_PORTS*C_AXIS_TUSER_WIDTH  packed per port.
- s_axis_tvalid  in  NUM_PORTS  one bit per port.
- s_axis_tlast  in  NUM_PORTS  one bit per port.
- s_axis_tready  out  NUM_PORTS  one bit per port.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged stream.
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH.
- m_axis_tvalid  out  1.
- m_axis_tready  in  1.
- m_axis_tlast  out  1.

Behaviour:
- Reset: all buffers empty; cur_port=0; state=IDLE; m_axis_tvalid=0; s_axis_tready=0 while axis_reset is high.
- Buffer i write enable: s_axis_tvalid[i] & s_axis_tready[i].
- Buffer i stores {tlast, tuser, tkeep, tdata} in fall-through mode; the head is visible the cycle after the write.
- s_axis_tready[i] = !nearly_full[i] & !axis_reset.
- nearly_full asserts when occupancy >= 2^FIFO_DEPTH_BITS - 1, which guarantees no overflow with one beat in flight.
- m_axis_* are driven combinationally from the head of buffer cur_port.
- m_axis_tvalid = !empty[cur_port].
- Buffer cur_port pops on m_axis_tvalid & m_axis_tready.
- State machine, two states:
  - IDLE, cur_port empty: cur_port jumps in one cycle to the first non-empty port searching cur_port+1, cur_port+2, ... mod NUM_PORTS. If all ports are empty it holds.
  - IDLE, head beat accepted with tlast=0: go to IN_PKT.
  - IDLE, head beat accepted with tlast=1 (single-beat packet): stay in IDLE; cur_port <= (cur_port+1) mod NUM_PORTS.
  - IN_PKT: cur_port is locked. If the buffer underruns mid-packet, m_axis_tvalid drops and the arbiter waits; it never switches ports.
  - IN_PKT, accepted beat with tlast=1: go to IDLE; cur_port <= (cur_port+1) mod NUM_PORTS.
- Fairness: after a packet completes, the port that just finished has the lowest priority. With all ports backlogged, output order is 0,1,..,N-1,0.
- Minimum latency: input beat at cycle t appears on m_axis at t+1 if cur_port already points at that port; t+2 if a hop is needed.
- Backpressure: while m_axis_tready=0, m_axis outputs hold stable and no pop occurs.
- Simultaneous events:
  - Push and pop on the same buffer in the same cycle keeps occupancy unchanged.
  - A new arrival on the port being skipped during a hop is served next round.
- Reset mid-packet: buffers flush immediately; state=IDLE; the partial packet is discarded (no tlast is emitted).
- Width rules: cur_port is $clog2(NUM_PORTS) bits; the modulo wrap is explicit when NUM_PORTS is not a power of 2.

Optional Feature:
- Macro: AXIS_RR_INPUT_ARBITER_STATS_EN.
- When defined, adds ports:
  - pkt_cnt  out  NUM_PORTS*32  per-port count of packets forwarded on m_axis, incremented on accepted tlast beats.
  - pkt_cnt_clear  in  1.
- Counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- Clear takes priority over a same-cycle increment, and the result is 0.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Port 2 only, 3-beat packet (tlast on beat 3), m_axis_tready=1 -> three m_axis beats from port 2, tlast on the third; state returns to IDLE; cur_port=3.
- Ports 0,1,4 each hold one 2-beat packet at time 0 -> output order is port 0, port 1, port 4 packets; no interleaving; tuser of each beat matches its source.
- m_axis_tready=0 for 20 cycles while port 1 streams -> s_axis_tready[1] falls after 3 beats are buffered; no beat is lost or duplicated after tready returns to 1.
- Port 0 mid-packet underruns for 5 cycles while port 3 has data -> m_axis_tvalid=0 for those cycles; port 3 is served only after port 0's tlast.
- axis_reset pulses during beat 2 of a 4-beat packet -> m_axis_tvalid=0 next cycle; buffers empty; cur_port=0; the next packet is forwarded cleanly.
- STATS_EN: 0xFFFFFFFF preload is not available, so send 3 packets on port 4 then raise pkt_cnt_clear coincident with a fourth tlast -> pkt_cnt[4] reads 3 and then 0.

Source files
------------

// File: rtl/axis_rr_input_arbiter.sv
// Merges NUM_PORTS AXI4-Stream inputs into one stream with packet-granular round-robin.
// Optional per-port forwarded-packet counters: define AXIS_RR_INPUT_ARBITER_STATS_EN.
module axis_rr_input_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 5,
    parameter int FIFO_DEPTH_BITS    = 2
) (
    input  logic                                      axis_aclk,
    input  logic                                      axis_reset,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [NUM_PORTS-1:0]                      s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic                                      m_axis_tlast
`ifdef AXIS_RR_INPUT_ARBITER_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]                   pkt_cnt,
    input  logic                                      pkt_cnt_clear
`endif
);

    localparam int DW      = C_AXIS_DATA_WIDTH;
    localparam int TU      = C_AXIS_TUSER_WIDTH;
    localparam int KEEP_W  = C_AXIS_DATA_WIDTH / 8;
    localparam int ENTRY_W = 1 + TU + KEEP_W + DW;
    localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
    localparam int CNT_W   = FIFO_DEPTH_BITS + 1;
    localparam int PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PORT_W-1:0]    cur_port_r;
    logic [PORT_W-1:0]    cur_port_nxt_s;
    logic [PORT_W-1:0]    port_inc_s;
    logic [PORT_W-1:0]    hop_port_s;
    logic [PORT_W-1:0]    hop_idx_s;
    logic [PORT_W:0]      hop_sum_s;
    logic [NUM_PORTS-1:0] empty_s;
    logic [NUM_PORTS-1:0] pop_s;
    logic [ENTRY_W-1:0]   head_s [NUM_PORTS];
    logic [ENTRY_W-1:0]   out_entry_s;
    logic                 accept_s;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
        logic [ENTRY_W-1:0]         mem_r [DEPTH];
        logic [FIFO_DEPTH_BITS-1:0] wr_ptr_r;
        logic [FIFO_DEPTH_BITS-1:0] rd_ptr_r;
        logic [CNT_W-1:0]           count_r;
        logic                       push_s;

        assign push_s = s_axis_tvalid[i] & s_axis_tready[i];

        // Entry storage; validity is tracked by the pointers, so no reset is needed
        always_ff @(posedge axis_aclk) begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {s_axis_tlast[i], s_axis_tuser[i*TU +: TU],
                                    s_axis_tkeep[i*KEEP_W +: KEEP_W], s_axis_tdata[i*DW +: DW]};
            end
        end

        // Pointer and occupancy tracking; reset flushes the buffer immediately
        always_ff @(posedge axis_aclk or posedge axis_reset) begin
            if (axis_reset) begin
                wr_ptr_r <= FIFO_DEPTH_BITS'(0);
                rd_ptr_r <= FIFO_DEPTH_BITS'(0);
                count_r  <= CNT_W'(0);
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + FIFO_DEPTH_BITS'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r <= rd_ptr_r + FIFO_DEPTH_BITS'(1);
                end
                case ({push_s, pop_s[i]})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end

        // One slot of headroom covers the beat already in flight when tready drops
        assign empty_s[i]       = (count_r == CNT_W'(0));
        assign s_axis_tready[i] = (count_r < CNT_W'(DEPTH - 1)) & ~axis_reset;
        assign head_s[i]        = mem_r[rd_ptr_r];
    end

    assign out_entry_s   = head_s[cur_port_r];
    assign m_axis_tvalid = ~empty_s[cur_port_r];
    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = out_entry_s;
    assign accept_s      = m_axis_tvalid & m_axis_tready;
    assign port_inc_s    = (cur_port_r == PORT_W'(NUM_PORTS - 1)) ? PORT_W'(0)
                                                                   : cur_port_r + PORT_W'(1);

    // Only the selected buffer pops
    always_comb begin
        pop_s = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop_s[i] = accept_s & (cur_port_r == PORT_W'(i));
        end
    end

    // Nearest non-empty port after cur_port_r; walking from farthest to nearest lets the nearest win
    always_comb begin
        hop_port_s = cur_port_r;
        hop_sum_s  = {1'b0, cur_port_r};
        hop_idx_s  = cur_port_r;
        for (int k = NUM_PORTS - 1; k >= 1; k--) begin
            hop_sum_s  = {1'b0, cur_port_r} + (PORT_W + 1)'(k);
            hop_idx_s  = (hop_sum_s >= (PORT_W + 1)'(NUM_PORTS))
                         ? PORT_W'(hop_sum_s - (PORT_W + 1)'(NUM_PORTS))
                         : PORT_W'(hop_sum_s);
            hop_port_s = empty_s[hop_idx_s] ? hop_port_s : hop_idx_s;
        end
    end

    // Arbiter next state: hop while idle and empty, lock on the port for the whole packet
    always_comb begin
        state_nxt_s    = state_r;
        cur_port_nxt_s = cur_port_r;
        case (state_r)
            IDLE: begin
                if (empty_s[cur_port_r]) begin
                    cur_port_nxt_s = hop_port_s;
                end else if (accept_s) begin
                    if (m_axis_tlast) begin
                        cur_port_nxt_s = port_inc_s;
                    end else begin
                        state_nxt_s = IN_PKT;
                    end
                end else begin
                    cur_port_nxt_s = cur_port_r;
                end
            end
            IN_PKT: begin
                if (accept_s && m_axis_tlast) begin
                    state_nxt_s    = IDLE;
                    cur_port_nxt_s = port_inc_s;
                end else begin
                    state_nxt_s = IN_PKT;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                cur_port_nxt_s = PORT_W'(0);
            end
        endcase
    end

    // Arbiter state register
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state_r    <= IDLE;
            cur_port_r <= PORT_W'(0);
        end else begin
            state_r    <= state_nxt_s;
            cur_port_r <= cur_port_nxt_s;
        end
    end

`ifdef AXIS_RR_INPUT_ARBITER_STATS_EN
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stats
        logic [31:0] pkt_cnt_r;

        // Packets forwarded from this port; clear beats a same-cycle increment
        always_ff @(posedge axis_aclk or posedge axis_reset) begin
            if (axis_reset) begin
                pkt_cnt_r <= 32'd0;
            end else if (pkt_cnt_clear) begin
                pkt_cnt_r <= 32'd0;
            end else if (pop_s[i] && m_axis_tlast) begin
                pkt_cnt_r <= pkt_cnt_r + 32'd1;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
        end

        assign pkt_cnt[i*32 +: 32] = pkt_cnt_r;
    end
`else
    // Default build carries no packet counters.
`endif

endmodule
